// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH payload bits LSB first, optional parity, stop bit.
// Define UART_TX_PARITY_EN to build the parity bit; otherwise PAR_EN/PAR_TYP are ignored.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [5:0]            r_cnt;
    logic [BW-1:0]         r_bit;
    logic [DATA_WIDTH-1:0] r_data;
    logic [5:0]            r_presc;
    logic                  r_tx;
    logic                  r_busy;

    state_t                w_state_nxt;
    logic [5:0]            w_cnt_nxt;
    logic [5:0]            w_cnt_step;
    logic [BW-1:0]         w_bit_nxt;
    logic                  w_bit_done;
    logic                  w_tx_nxt;
    logic                  w_busy_nxt;
    logic                  w_start_req;

`ifdef UART_TX_PARITY_EN
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  w_parity;

    assign w_parity = (^r_data) ^ r_par_typ;
`else
    logic                  w_unused_par;

    assign w_unused_par = PAR_EN ^ PAR_TYP;
`endif

    assign w_start_req = (r_state == S_IDLE) && DATA_VALID;
    assign w_bit_done  = (r_cnt == r_presc - 6'd1);
    assign w_cnt_step  = w_bit_done ? 6'd0 : r_cnt + 6'd1;

    // State, counters and registered line outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Request fields are captured only on acceptance and held for the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_presc <= 6'd0;
`ifdef UART_TX_PARITY_EN
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
`endif
        end else if (w_start_req) begin
            r_data  <= P_DATA;
            r_presc <= (Prescale == 6'd0) ? 6'd1 : Prescale;
`ifdef UART_TX_PARITY_EN
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = 6'd0;
        w_bit_nxt   = '0;
        case (r_state)
            S_IDLE: begin
                if (DATA_VALID) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_cnt_nxt = w_cnt_step;
                if (w_bit_done) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_cnt_nxt = w_cnt_step;
                w_bit_nxt = r_bit;
                if (w_bit_done) begin
                    if (r_bit == LAST_BIT) begin
                        w_bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = r_par_en ? S_PARITY : S_STOP;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_cnt_nxt = w_cnt_step;
                if (w_bit_done) begin
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                w_cnt_nxt = w_cnt_step;
                if (w_bit_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it
    always_comb begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b1;
        case (w_state_nxt)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
            end
            S_START: begin
                w_tx_nxt = 1'b0;
            end
            S_DATA: begin
                w_tx_nxt = r_data[w_bit_nxt];
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_tx_nxt = w_parity;
            end
`endif
            S_STOP: begin
                w_tx_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    assign TX_OUT = r_tx;
    assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of frames plus back-to-back and mid-frame reset sequences.
// Expectations follow the UART_TX_PARITY_EN setting of the build.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        logic [5:0]  presc;
        int          n;
        logic [11:0] seq;
        int          nbits;
        int          busy_len;
    } vec_t;

    vec_t tv [8];

    function automatic vec_t mkv(input logic [7:0] d, input logic pe,
                                 input logic pt, input logic [5:0] presc,
                                 input int n, input logic parbit,
                                 input int busy_p, input int busy_np);
        vec_t v;
        v.data  = d;
        v.pe    = pe;
        v.pt    = pt;
        v.presc = presc;
        v.n     = n;
        if (PAR_BUILD && pe) begin
            v.seq      = {1'b1, parbit, d, 1'b0};
            v.nbits    = 11;
            v.busy_len = busy_p;
        end else begin
            v.seq      = {2'b01, d, 1'b0};
            v.nbits    = 10;
            v.busy_len = busy_np;
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] d, input logic pe,
                               input logic pt, input logic [5:0] presc);
        @(negedge clk);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Prescale   = presc;
        DATA_VALID = 1'b1;
        @(negedge clk);
        DATA_VALID = 1'b0;
    endtask

    // Called one negedge after the accepting edge; returns on the first idle negedge
    task automatic check_frame(input logic [11:0] seq, input int nbits,
                               input int n, input int exp_busy,
                               input bit disturb, input string tag);
        int  cnt;
        int  idx;
        logic eb;
        cnt = 0;
        while (busy === 1'b1 && cnt < 400) begin
            idx = cnt / n;
            eb  = (idx < nbits) ? seq[idx[3:0]] : 1'b1;
            chk($sformatf("%s_tx_c%0d", tag, cnt), {31'd0, TX_OUT}, {31'd0, eb});
            if (disturb && cnt == 2) begin
                Prescale = 6'd7;
                PAR_EN   = 1'b1;
                PAR_TYP  = 1'b1;
            end
            if (disturb && cnt == 5) begin
                Prescale = 6'd2;
                PAR_EN   = 1'b0;
                PAR_TYP  = 1'b0;
            end
            cnt++;
            @(negedge clk);
        end
        chk($sformatf("%s_busy_len", tag), cnt, exp_busy);
        chk($sformatf("%s_idle_tx", tag), {31'd0, TX_OUT}, 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        DATA_VALID = 1'b0;
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescale   = 6'd0;

        tv[0] = mkv(8'hA5, 1'b1, 1'b0, 6'd8, 8, 1'b0, 88, 80);
        tv[1] = mkv(8'h01, 1'b1, 1'b1, 6'd4, 4, 1'b0, 44, 40);
        tv[2] = mkv(8'h03, 1'b1, 1'b1, 6'd4, 4, 1'b1, 44, 40);
        tv[3] = mkv(8'hFF, 1'b0, 1'b0, 6'd1, 1, 1'b0, 10, 10);
        tv[4] = mkv(8'hFF, 1'b0, 1'b0, 6'd0, 1, 1'b0, 10, 10);
        tv[5] = mkv(8'h3C, 1'b1, 1'b0, 6'd2, 2, 1'b0, 22, 20);
        tv[6] = mkv(8'h00, 1'b1, 1'b1, 6'd3, 3, 1'b1, 33, 30);
        tv[7] = mkv(8'h97, 1'b1, 1'b0, 6'd5, 5, 1'b1, 55, 50);

        // Request while in reset must not start a frame
        repeat (2) @(negedge clk);
        DATA_VALID = 1'b1;
        P_DATA     = 8'h12;
        Prescale   = 6'd1;
        @(negedge clk);
        chk("reset_tx", {31'd0, TX_OUT}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        DATA_VALID = 1'b0;
        rst        = 1'b0;
        @(negedge clk);
        chk("post_reset_busy", {31'd0, busy}, 32'd0);
        chk("post_reset_tx", {31'd0, TX_OUT}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            start_frame(tv[i].data, tv[i].pe, tv[i].pt, tv[i].presc);
            check_frame(tv[i].seq, tv[i].nbits, tv[i].n, tv[i].busy_len,
                        1'b0, $sformatf("v%0d", i));
        end

        // Back-to-back: request held, payload and controls disturbed mid-frame
        @(negedge clk);
        P_DATA     = 8'h55;
        Prescale   = 6'd2;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        DATA_VALID = 1'b1;
        @(negedge clk);
        P_DATA = 8'hAA;
        check_frame({2'b01, 8'h55, 1'b0}, 10, 2, 20, 1'b1, "b2b_first");
        chk("b2b_gap_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        DATA_VALID = 1'b0;
        check_frame({2'b01, 8'hAA, 1'b0}, 10, 2, 20, 1'b0, "b2b_second");

        // Reset during data bit 3 (frame bit 4, cycles 16..19 at N=4)
        start_frame(8'hA5, 1'b0, 1'b0, 6'd4);
        repeat (17) @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_tx_bit3", {31'd0, TX_OUT}, 32'd0);
        rst        = 1'b1;
        DATA_VALID = 1'b1;
        @(negedge clk);
        chk("abort_tx", {31'd0, TX_OUT}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        rst        = 1'b0;
        DATA_VALID = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("after_abort_tx%0d", k), {31'd0, TX_OUT}, 32'd1);
            chk($sformatf("after_abort_busy%0d", k), {31'd0, busy}, 32'd0);
        end
        start_frame(8'h3C, 1'b0, 1'b0, 6'd2);
        check_frame({2'b01, 8'h3C, 1'b0}, 10, 2, 20, 1'b0, "clean");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
